// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS32 pipeline registers: control-word bit
// positions, the default bubble control word and default field widths.
package mips_pipe_pkg;

    localparam int CTRL_W_DEFAULT     = 8;
    localparam int REG_ADDR_W_DEFAULT = 5;

    // Bit positions inside the packed control word.
    localparam int CTRL_REGDST   = 0;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_ALUOP    = 7;

    // A bubble must never write the register file or memory, nor branch.
    localparam logic [CTRL_W_DEFAULT-1:0] NOP_CTRL_DEFAULT = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: synchronous reset and flush load RST_VAL,
// stall holds, otherwise the input is captured.
module pipe_field_reg #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    // Flush outranks stall so a bubble can replace a held instruction.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            q_reg <= RST_VAL;
        end else if (!stall) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with stall, flush (bubble), valid tracking and a
// saturating count of inserted bubbles.
module id_ex_pipeline_reg
    import mips_pipe_pkg::*;
#(
    parameter int                CTRL_W     = CTRL_W_DEFAULT,
    parameter int                DATA_W     = 32,
    parameter int                REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter logic [CTRL_W-1:0] NOP_CTRL   = CTRL_W'(NOP_CTRL_DEFAULT),
    parameter int                CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [DATA_W-1:0]     in_rs_data,
    input  logic [DATA_W-1:0]     in_rt_data,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [DATA_W-1:0]     in_pc_plus4,
    input  logic [REG_ADDR_W-1:0] in_rs_addr,
    input  logic [REG_ADDR_W-1:0] in_rt_addr,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    output logic                  out_valid,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [DATA_W-1:0]     out_rs_data,
    output logic [DATA_W-1:0]     out_rt_data,
    output logic [DATA_W-1:0]     out_imm,
    output logic [DATA_W-1:0]     out_pc_plus4,
    output logic [REG_ADDR_W-1:0] out_rs_addr,
    output logic [REG_ADDR_W-1:0] out_rt_addr,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic [CNT_W-1:0]      out_bubble_count
);

    localparam int N_DATA = 4;
    localparam int N_ADDR = 3;

    logic [DATA_W-1:0]     data_d [N_DATA];
    logic [DATA_W-1:0]     data_q [N_DATA];
    logic [REG_ADDR_W-1:0] addr_d [N_ADDR];
    logic [REG_ADDR_W-1:0] addr_q [N_ADDR];
    logic [CTRL_W-1:0]     ctrl_d;
    logic [CNT_W-1:0]      bubble_count_reg;
    logic [CNT_W-1:0]      bubble_count_next;

    assign data_d[0] = in_rs_data;
    assign data_d[1] = in_rt_data;
    assign data_d[2] = in_imm;
    assign data_d[3] = in_pc_plus4;
    assign addr_d[0] = in_rs_addr;
    assign addr_d[1] = in_rt_addr;
    assign addr_d[2] = in_rd_addr;

    // An invalid decode slot must not carry side effects into EX, so its
    // control word is replaced; its data is still copied verbatim.
    assign ctrl_d = in_valid ? in_ctrl : NOP_CTRL;

    genvar gi;
    generate
        for (gi = 0; gi < N_DATA; gi++) begin : g_data
            pipe_field_reg #(.W(DATA_W), .RST_VAL({DATA_W{1'b0}})) u_data (
                .clock(clock), .reset(reset), .stall(stall), .flush(flush),
                .d(data_d[gi]), .q(data_q[gi])
            );
        end
        for (gi = 0; gi < N_ADDR; gi++) begin : g_addr
            pipe_field_reg #(.W(REG_ADDR_W), .RST_VAL({REG_ADDR_W{1'b0}})) u_addr (
                .clock(clock), .reset(reset), .stall(stall), .flush(flush),
                .d(addr_d[gi]), .q(addr_q[gi])
            );
        end
    endgenerate

    pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_valid (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .d(in_valid), .q(out_valid)
    );

    pipe_field_reg #(.W(CTRL_W), .RST_VAL(NOP_CTRL)) u_ctrl (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .d(ctrl_d), .q(out_ctrl)
    );

    // Flush wins over stall, so the counter only needs to look at flush.
    always_comb begin
        bubble_count_next = bubble_count_reg;
        if (flush && (bubble_count_reg != {CNT_W{1'b1}})) begin
            bubble_count_next = bubble_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bubble_count_reg <= '0;
        end else begin
            bubble_count_reg <= bubble_count_next;
        end
    end

    assign out_rs_data      = data_q[0];
    assign out_rt_data      = data_q[1];
    assign out_imm          = data_q[2];
    assign out_pc_plus4     = data_q[3];
    assign out_rs_addr      = addr_q[0];
    assign out_rt_addr      = addr_q[1];
    assign out_rd_addr      = addr_q[2];
    assign out_bubble_count = bubble_count_reg;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for id_ex_pipeline_reg: a default instance plus a 4-bit
// counter instance with a non-zero bubble control word.
module tb_id_ex_pipeline_reg;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, stall, flush, in_valid;
    logic [7:0]  in_ctrl;
    logic [31:0] in_rs_data, in_rt_data, in_imm, in_pc_plus4;
    logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
    logic        out_valid;
    logic [7:0]  out_ctrl;
    logic [31:0] out_rs_data, out_rt_data, out_imm, out_pc_plus4;
    logic [4:0]  out_rs_addr, out_rt_addr, out_rd_addr;
    logic [15:0] out_bubble_count;

    logic        s_reset, s_flush;
    logic        s_out_valid;
    logic [7:0]  s_out_ctrl;
    logic [31:0] s_out_rs_data, s_out_rt_data, s_out_imm, s_out_pc_plus4;
    logic [4:0]  s_out_rs_addr, s_out_rt_addr, s_out_rd_addr;
    logic [3:0]  s_out_bubble_count;

    int checks = 0;
    int errors = 0;

    id_ex_pipeline_reg dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_imm(in_imm), .in_pc_plus4(in_pc_plus4),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
        .out_valid(out_valid), .out_ctrl(out_ctrl),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
        .out_imm(out_imm), .out_pc_plus4(out_pc_plus4),
        .out_rs_addr(out_rs_addr), .out_rt_addr(out_rt_addr), .out_rd_addr(out_rd_addr),
        .out_bubble_count(out_bubble_count)
    );

    id_ex_pipeline_reg #(.CNT_W(4), .NOP_CTRL(8'h80)) dut_small (
        .clock(clock), .reset(s_reset), .stall(1'b0), .flush(s_flush),
        .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_imm(in_imm), .in_pc_plus4(in_pc_plus4),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
        .out_valid(s_out_valid), .out_ctrl(s_out_ctrl),
        .out_rs_data(s_out_rs_data), .out_rt_data(s_out_rt_data),
        .out_imm(s_out_imm), .out_pc_plus4(s_out_pc_plus4),
        .out_rs_addr(s_out_rs_addr), .out_rt_addr(s_out_rt_addr), .out_rd_addr(s_out_rd_addr),
        .out_bubble_count(s_out_bubble_count)
    );

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] ra, input logic [4:0] ta, input logic [4:0] da);
        in_valid = v; in_ctrl = c; in_rs_data = rs; in_rt_data = rt;
        in_imm = imm; in_pc_plus4 = pc; in_rs_addr = ra; in_rt_addr = ta; in_rd_addr = da;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_reset = 1'b1; stall = 1'b0; flush = 1'b0; s_flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'($urandom), $urandom, $urandom, $urandom, $urandom,
                  5'($urandom), 5'($urandom), 5'($urandom));
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_bubble_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b ctrl=%h cnt=%0d required 0/00/0",
                     out_valid, out_ctrl, out_bubble_count);
        end
        checks++;
        if ({out_rs_data, out_rt_data, out_imm, out_pc_plus4} !== 128'd0 ||
            {out_rs_addr, out_rt_addr, out_rd_addr} !== 15'd0) begin
            errors++;
            $display("FAIL reset_data: rs=%h rt=%h imm=%h pc=%h addr=%h/%h/%h required all 0",
                     out_rs_data, out_rt_data, out_imm, out_pc_plus4,
                     out_rs_addr, out_rt_addr, out_rd_addr);
        end
        checks++;
        if (s_out_ctrl !== 8'h80 || s_out_valid !== 1'b0 || s_out_bubble_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_small: ctrl=%h valid=%b cnt=%0d required 80/0/0",
                     s_out_ctrl, s_out_valid, s_out_bubble_count);
        end
        $display("reset: outputs cleared");
        reset = 1'b0; s_reset = 1'b0;
    endtask

    task automatic test_pass_through();
        drive(1'b1, 8'hA5, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFF4, 32'h0040_0004,
              5'd3, 5'd9, 5'd17);
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_rs_data !== 32'd0) begin
            errors++;
            $display("FAIL no_comb_path: valid=%b ctrl=%h rs=%h required 0/00/00000000 before edge",
                     out_valid, out_ctrl, out_rs_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 8'hA5 || out_rs_data !== 32'h1234_5678 ||
            out_rt_data !== 32'h9ABC_DEF0 || out_imm !== 32'hFFFF_FFF4 ||
            out_pc_plus4 !== 32'h0040_0004) begin
            errors++;
            $display("FAIL pass_data: valid=%b ctrl=%h rs=%h rt=%h imm=%h pc=%h required 1/a5/12345678/9abcdef0/fffffff4/00400004",
                     out_valid, out_ctrl, out_rs_data, out_rt_data, out_imm, out_pc_plus4);
        end
        checks++;
        if (out_rs_addr !== 5'd3 || out_rt_addr !== 5'd9 || out_rd_addr !== 5'd17 ||
            out_bubble_count !== 16'd0) begin
            errors++;
            $display("FAIL pass_addr: rs=%0d rt=%0d rd=%0d cnt=%0d required 3/9/17/0",
                     out_rs_addr, out_rt_addr, out_rd_addr, out_bubble_count);
        end
        $display("pass_through: ctrl=%h rs=%h rd=%0d", out_ctrl, out_rs_data, out_rd_addr);
    endtask

    task automatic test_stall();
        drive(1'b1, 8'h3C, 32'h0BAD_F00D, 32'h1111_2222, 32'h0000_0010, 32'h0040_0008,
              5'd4, 5'd5, 5'd6);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_ctrl !== 8'hA5 || out_valid !== 1'b1 || out_rs_data !== 32'h1234_5678 ||
                out_rd_addr !== 5'd17) begin
                errors++;
                $display("FAIL stall_hold_%0d: ctrl=%h valid=%b rs=%h rd=%0d required a5/1/12345678/17",
                         i, out_ctrl, out_valid, out_rs_data, out_rd_addr);
            end
            $display("stall edge %0d: ctrl=%h", i, out_ctrl);
        end
        stall = 1'b0;
        step();
        checks++;
        if (out_ctrl !== 8'h3C || out_rs_data !== 32'h0BAD_F00D || out_imm !== 32'h0000_0010 ||
            out_rd_addr !== 5'd6 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: ctrl=%h rs=%h imm=%h rd=%0d valid=%b required 3c/0badf00d/00000010/6/1",
                     out_ctrl, out_rs_data, out_imm, out_rd_addr, out_valid);
        end
        $display("stall release: ctrl=%h", out_ctrl);
    endtask

    task automatic test_flush_priority();
        stall = 1'b1; flush = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_rs_data !== 32'd0 ||
            out_pc_plus4 !== 32'd0 || out_rd_addr !== 5'd0) begin
            errors++;
            $display("FAIL flush_bubble: valid=%b ctrl=%h rs=%h pc=%h rd=%0d required 0/00/0/0/0",
                     out_valid, out_ctrl, out_rs_data, out_pc_plus4, out_rd_addr);
        end
        checks++;
        if (out_bubble_count !== 16'd1) begin
            errors++;
            $display("FAIL flush_count: cnt=%0d required 1", out_bubble_count);
        end
        $display("flush+stall: valid=%b cnt=%0d", out_valid, out_bubble_count);
        // Stall alone must also freeze the counter.
        flush = 1'b0;
        step();
        checks++;
        if (out_bubble_count !== 16'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_count_hold: cnt=%0d valid=%b required 1/0",
                     out_bubble_count, out_valid);
        end
        stall = 1'b0;
    endtask

    task automatic test_invalid_input();
        drive(1'b0, 8'hFF, 32'hDEAD_BEEF, 32'hCAFE_0001, 32'h0000_0020, 32'h0040_000C,
              5'd1, 5'd2, 5'd31);
        step();
        checks++;
        if (out_ctrl !== 8'h00 || out_valid !== 1'b0 || out_bubble_count !== 16'd1) begin
            errors++;
            $display("FAIL invalid_ctrl: ctrl=%h valid=%b cnt=%0d required 00/0/1",
                     out_ctrl, out_valid, out_bubble_count);
        end
        checks++;
        if (out_rs_data !== 32'hDEAD_BEEF || out_rd_addr !== 5'd31) begin
            errors++;
            $display("FAIL invalid_data: rs=%h rd=%0d required deadbeef/31",
                     out_rs_data, out_rd_addr);
        end
        $display("invalid input: ctrl=%h rs=%h", out_ctrl, out_rs_data);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ctrl_tab [4];
        logic [31:0] data_tab [4];
        ctrl_tab = '{8'h01, 8'h28, 8'h9E, 8'h77};
        data_tab = '{32'h0000_0001, 32'h8000_0000, 32'h5555_AAAA, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ctrl_tab[i], data_tab[i], ~data_tab[i], data_tab[i] ^ 32'h0F0F_0F0F,
                  32'h0040_0100 + 32'(i * 4), 5'(i), 5'(i + 8), 5'(i + 20));
            step();
            checks++;
            if (out_ctrl !== ctrl_tab[i] || out_rs_data !== data_tab[i] ||
                out_rt_data !== ~data_tab[i] || out_pc_plus4 !== 32'h0040_0100 + 32'(i * 4) ||
                out_rd_addr !== 5'(i + 20) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back_%0d: ctrl=%h rs=%h rt=%h pc=%h rd=%0d valid=%b required %h/%h/%h/%h/%0d/1",
                         i, out_ctrl, out_rs_data, out_rt_data, out_pc_plus4, out_rd_addr, out_valid,
                         ctrl_tab[i], data_tab[i], ~data_tab[i], 32'h0040_0100 + 32'(i * 4), i + 20);
            end
            $display("back_to_back %0d: ctrl=%h rs=%h", i, out_ctrl, out_rs_data);
        end
    endtask

    task automatic test_reset_during_stall();
        stall = 1'b1; reset = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_rs_data !== 32'd0 ||
            out_bubble_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_in_stall: valid=%b ctrl=%h rs=%h cnt=%0d required 0/00/0/0",
                     out_valid, out_ctrl, out_rs_data, out_bubble_count);
        end
        reset = 1'b0; stall = 1'b0;
        drive(1'b1, 8'h42, 32'h0000_BEEF, 32'd0, 32'd0, 32'd4, 5'd7, 5'd8, 5'd9);
        step();
        checks++;
        if (out_ctrl !== 8'h42 || out_rs_data !== 32'h0000_BEEF || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_load: ctrl=%h rs=%h valid=%b required 42/0000beef/1",
                     out_ctrl, out_rs_data, out_valid);
        end
        $display("reset in stall then load: ctrl=%h", out_ctrl);
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        s_flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            exp_cnt = (i + 1 >= 15) ? 4'd15 : 4'(i + 1);
            checks++;
            if (s_out_bubble_count !== exp_cnt || s_out_ctrl !== 8'h80 || s_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL saturate_%0d: cnt=%0d ctrl=%h valid=%b required %0d/80/0",
                         i, s_out_bubble_count, s_out_ctrl, s_out_valid, exp_cnt);
            end
        end
        $display("saturation: cnt=%0d after 20 flushes", s_out_bubble_count);
        s_flush = 1'b0; s_reset = 1'b1;
        step();
        checks++;
        if (s_out_bubble_count !== 4'd0) begin
            errors++;
            $display("FAIL saturate_reset: cnt=%0d required 0", s_out_bubble_count);
        end
        s_reset = 1'b0;
        $display("saturation reset: cnt=%0d", s_out_bubble_count);
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_stall();
        test_flush_priority();
        test_invalid_input();
        test_back_to_back();
        test_reset_during_stall();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipeline_reg.md
# id_ex_pipeline_reg

Parametrised ID/EX pipeline register for the MIPS32 datapath. It carries the full decoded control word and operand bundle from the decode stage to the execute stage in one clocked stage. Compared with the per-signal control registers, it adds hazard handling: stall (hold), flush (bubble insertion) and synchronous reset, plus a valid bit and a saturating bubble counter for performance observation.

## Interface
- CTRL_W, 8: width of the packed control word (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp…)
- DATA_W, 32: width of register-file operands, immediate and PC+4
- REG_ADDR_W, 5: register-number width
- NOP_CTRL, {CTRL_W{1'b0}}: control word driven during a bubble; must have no architectural side effect
- CNT_W, 16: bubble-counter width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold the current contents (load-use hazard)
- flush  in  1  replace the next contents with a bubble (branch taken / hazard)
- in_valid  in  1  decode stage holds a real instruction
- in_ctrl  in  CTRL_W  decoded control word
- in_rs_data, in_rt_data  in  DATA_W  register-file read data
- in_imm  in  DATA_W  sign-extended immediate
- in_pc_plus4  in  DATA_W  PC+4 of the instruction
- in_rs_addr, in_rt_addr, in_rd_addr  in  REG_ADDR_W  register numbers
- out_valid  out  1  execute stage holds a real instruction
- out_ctrl  out  CTRL_W
- out_rs_data, out_rt_data, out_imm, out_pc_plus4  out  DATA_W
- out_rs_addr, out_rt_addr, out_rd_addr  out  REG_ADDR_W
- out_bubble_count  out  CNT_W  number of bubbles inserted since reset, saturating

## Operation
Update action on each rising clock edge, highest priority first:
- **reset=1**: out_valid=0, out_ctrl=NOP_CTRL, all data, address and counter outputs = 0.
- **flush=1**: bubble. out_valid=0, out_ctrl=NOP_CTRL, all data and address outputs = 0. Counter +1. Flush wins over a simultaneous stall.
- **stall=1**: every output holds its value, including out_valid and the counter.
- **otherwise**: load. out_valid=in_valid. All fields are copied from the inputs. If in_valid=0, out_ctrl=NOP_CTRL, regardless of in_ctrl; data fields are still copied. The counter does not change.

Counter rules:
- Increments only on flush cycles.
- Saturates at 2^CNT_W−1; it never wraps.
- Cleared only by reset.

Other rules:
- All outputs are registered. There is no combinational input-to-output path.
- No width conversion is done; each field is stored verbatim.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- A stall of k cycles holds the outputs for k edges. The held instruction reaches EX once, not duplicated.
- A reset in the middle of a stall or flush takes effect at that edge. The next non-reset edge behaves normally.
- The outputs are undefined only before the first reset edge. The bench must apply reset first.

## Structure
- Shared package `mips_pipe_pkg` holds:
  - the control-word bit positions as localparams (CTRL_REGWRITE, CTRL_MEMWRITE, …)
  - the default NOP_CTRL constant
  - the REG_ADDR_W default
- Natural sub-module: `pipe_field_reg #(W, RST_VAL)`. It is a generic reset/flush/stall register used once per field. The top level adds the valid-gating of out_ctrl and the saturating counter.

## Test plan
- **Reset**: drive reset=1 for 2 cycles with random inputs -> every output is 0 and out_ctrl=NOP_CTRL.
- **Pass-through**: in_valid=1, in_ctrl=0xA5, in_rs_data=0x12345678, in_rd_addr=17 -> the values appear exactly one edge later with out_valid=1.
- **Stall**: load 0xA5, then stall=1 for 3 cycles while the inputs change to 0x3C -> the outputs stay 0xA5 for 3 edges and take 0x3C on the first edge after stall drops.
- **Flush priority**: stall=1 and flush=1 together -> out_valid=0, out_ctrl=NOP_CTRL, data outputs 0, out_bubble_count goes 0->1.
- **Invalid input**: in_valid=0 with in_ctrl=0xFF -> out_ctrl=NOP_CTRL, out_valid=0, counter unchanged.
- **Saturation**: CNT_W=4 with 20 consecutive flushes -> the counter reaches 15 and stays there. A following reset clears it to 0.
